// File: rtl/pedx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pedx_pkg
//  Description : Shared definitions for the pedestrian crossing controller:
//                state encoding, default timing constants and a helper that
//                sizes phase counters from their terminal count.
//  Revision    : 1.0  initial release
// ============================================================================
package pedx_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_WALK  = 3'd2,
        S_FLASH = 3'd3,
        S_FAULT = 3'd4
    } pedx_state_t;

    // Default timing in clock cycles.
    localparam int c_DEB_CYCLES_DEFAULT   = 3;
    localparam int c_WALK_CYCLES_DEFAULT  = 2;
    localparam int c_FLASH_CYCLES_DEFAULT = 3;

    // Bits needed to hold the values 0 .. n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : pedx_pkg
`default_nettype wire

// File: rtl/ped_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : ped_debounce
//  Description : Two-flop synchronizer followed by a debouncer for the raw
//                pedestrian button. Emits a single-cycle press_pulse once
//                DEB_CYCLES consecutive synchronized samples are high after
//                a low sample. A held button yields exactly one pulse.
//  Ports       : clk         - clock, rising edge
//                rst         - asynchronous active-high reset
//                btn_raw     - raw button, asynchronous to clk
//                press_pulse - registered one-cycle accepted-press pulse
//  Revision    : 1.0  initial release
// ============================================================================
module ped_debounce
    import pedx_pkg::*;
#(
    parameter int DEB_CYCLES = c_DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_pulse
);

    // The counter must be able to hold DEB_CYCLES itself so it can saturate
    // there while the button stays held.
    localparam int c_CNT_W = cnt_width(DEB_CYCLES + 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_cnt       <= '0;
            press_pulse <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            if (!r_sync2) begin
                // Any low sample restarts the qualification window.
                r_cnt       <= '0;
                press_pulse <= 1'b0;
            end else if (r_cnt != c_CNT_W'(DEB_CYCLES)) begin
                r_cnt       <= r_cnt + c_CNT_W'(1);
                press_pulse <= (r_cnt == c_CNT_W'(DEB_CYCLES - 1));
            end else begin
                // Saturated: button still held, no further pulses.
                press_pulse <= 1'b0;
            end
        end
    end

endmodule : ped_debounce
`default_nettype wire

// File: rtl/ped_crossing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ped_crossing_ctrl
//  Description : Pedestrian crossing controller slaved to an upstream vehicle
//                traffic light. A debounced button press requests a crossing;
//                walk is granted on the next vehicle-red rising edge, held for
//                WALK_CYCLES, followed by FLASH_CYCLES of blinking don't-walk.
//                Loss of vehicle red aborts the crossing back to WAIT; any
//                non-one-hot lamp input latches a FAULT cleared only by rst.
//  Ports       : clk, rst                        - clock / async high reset
//                veh_red, veh_green, veh_yellow  - vehicle lamp state
//                ped_btn                         - raw pedestrian button
//                walk, dont_walk                 - pedestrian lamps
//                wait_lamp                       - request-pending indicator
//                fault                           - sticky lamp-input fault
//  Revision    : 1.0  initial release
// ============================================================================
module ped_crossing_ctrl
    import pedx_pkg::*;
#(
    parameter int DEB_CYCLES   = c_DEB_CYCLES_DEFAULT,
    parameter int WALK_CYCLES  = c_WALK_CYCLES_DEFAULT,
    parameter int FLASH_CYCLES = c_FLASH_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic veh_red,
    input  logic veh_green,
    input  logic veh_yellow,
    input  logic ped_btn,
    output logic walk,
    output logic dont_walk,
    output logic wait_lamp,
    output logic fault
);

    localparam int c_WALK_W  = cnt_width(WALK_CYCLES);
    localparam int c_FLASH_W = cnt_width(FLASH_CYCLES);

    pedx_state_t          r_state;
    logic                 r_prev_red;
    logic                 r_pending;
    logic [c_WALK_W-1:0]  r_walk_cnt;
    logic [c_FLASH_W-1:0] r_flash_cnt;

    logic       w_press;
    logic [2:0] w_lamp_vec;
    logic       w_lamp_bad;
    logic       w_red_rise;

    ped_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (ped_btn),
        .press_pulse (w_press)
    );

    assign w_lamp_vec = {veh_red, veh_green, veh_yellow};
    assign w_lamp_bad = !((w_lamp_vec == 3'b100) ||
                          (w_lamp_vec == 3'b010) ||
                          (w_lamp_vec == 3'b001));
    // Only a genuine low-to-high transition grants walk, so a red that is
    // already lit when the request arrives must cycle round first.
    assign w_red_rise = veh_red && !r_prev_red;

    // All lamp outputs are registered here; the asynchronous reset drives
    // them straight to the safe state (don't-walk lit) without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_prev_red  <= 1'b0;
            r_pending   <= 1'b0;
            r_walk_cnt  <= '0;
            r_flash_cnt <= '0;
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
            wait_lamp   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            r_prev_red <= veh_red;

            if ((r_state != S_FAULT) && w_lamp_bad) begin
                r_state     <= S_FAULT;
                r_pending   <= 1'b0;
                r_walk_cnt  <= '0;
                r_flash_cnt <= '0;
                walk        <= 1'b0;
                dont_walk   <= 1'b1;
                wait_lamp   <= 1'b0;
                fault       <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_press) begin
                            r_state   <= S_WAIT;
                            wait_lamp <= 1'b1;
                        end
                    end

                    S_WAIT: begin
                        if (w_red_rise) begin
                            r_state    <= S_WALK;
                            r_walk_cnt <= '0;
                            walk       <= 1'b1;
                            dont_walk  <= 1'b0;
                            wait_lamp  <= 1'b0;
                        end
                    end

                    S_WALK: begin
                        if (!veh_red) begin
                            // Vehicles released early: abort and re-arm.
                            r_state    <= S_WAIT;
                            r_walk_cnt <= '0;
                            walk       <= 1'b0;
                            dont_walk  <= 1'b1;
                            wait_lamp  <= 1'b1;
                        end else if (r_walk_cnt == c_WALK_W'(WALK_CYCLES - 1)) begin
                            r_state     <= S_FLASH;
                            r_walk_cnt  <= '0;
                            r_flash_cnt <= '0;
                            r_pending   <= 1'b0;
                            walk        <= 1'b0;
                            dont_walk   <= 1'b1;
                        end else begin
                            r_walk_cnt <= r_walk_cnt + c_WALK_W'(1);
                        end
                    end

                    S_FLASH: begin
                        if (!veh_red) begin
                            r_state     <= S_WAIT;
                            r_flash_cnt <= '0;
                            r_pending   <= 1'b0;
                            dont_walk   <= 1'b1;
                            wait_lamp   <= 1'b1;
                        end else if (r_flash_cnt == c_FLASH_W'(FLASH_CYCLES - 1)) begin
                            // A press on the last flash cycle still counts.
                            r_flash_cnt <= '0;
                            r_pending   <= 1'b0;
                            dont_walk   <= 1'b1;
                            if (r_pending || w_press) begin
                                r_state   <= S_WAIT;
                                wait_lamp <= 1'b1;
                            end else begin
                                r_state   <= S_IDLE;
                                wait_lamp <= 1'b0;
                            end
                        end else begin
                            r_flash_cnt <= r_flash_cnt + c_FLASH_W'(1);
                            dont_walk   <= ~dont_walk;
                            if (w_press) begin
                                r_pending <= 1'b1;
                                wait_lamp <= 1'b1;
                            end
                        end
                    end

                    S_FAULT: begin
                        // Held until reset.
                        r_state <= S_FAULT;
                    end

                    default: begin
                        r_state     <= S_FAULT;
                        r_pending   <= 1'b0;
                        r_walk_cnt  <= '0;
                        r_flash_cnt <= '0;
                        walk        <= 1'b0;
                        dont_walk   <= 1'b1;
                        wait_lamp   <= 1'b0;
                        fault       <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule : ped_crossing_ctrl
`default_nettype wire
